// File: rtl/regfile_wb_scheduler.sv
// Purpose : arbitrates ALU/load writebacks onto the single register-file write
//           port and gates issue against a busy scoreboard of in-flight writes.
// Latency : grant in cycle T -> rf_we/rf_dst/rf_wdata presented in T+1 -> busy
//           bit clears at the end of T+1, so a dependent issue unstalls in T+2.
// Backpressure: a losing writeback source sees ready=0 and holds its request;
//           a hazarded instruction sees issue_stall=1 and is not accepted.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   issue_*  / issue_stall            decode-side instruction and hazard stall
//   alu_*    / alu_ready              ALU writeback request and grant
//   ld_*     / ld_ready               load writeback request and grant
//   rf_we, rf_dst, rf_wdata           registered register-file write port
//   stall_count                       saturating count of stalled issue cycles
module regfile_wb_scheduler #(
    parameter int NREG = 32,
    parameter int XLEN = 32,
    localparam int RW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [RW-1:0]   issue_rs1,
    input  logic [RW-1:0]   issue_rs2,
    input  logic [RW-1:0]   issue_rd,
    input  logic            issue_rd_we,
    output logic            issue_stall,
    input  logic            alu_valid,
    input  logic [RW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_value,
    output logic            alu_ready,
    input  logic            ld_valid,
    input  logic [RW-1:0]   ld_rd,
    input  logic [XLEN-1:0] ld_value,
    output logic            ld_ready,
    output logic            rf_we,
    output logic [RW-1:0]   rf_dst,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0]     stall_count
);

    logic [NREG-1:0] busy_q, busy_d;
    logic            rr_ptr_q, rr_ptr_d;    // 0: load wins next contest, 1: ALU wins
    logic            rf_we_q, rf_we_d;
    logic [RW-1:0]   rf_dst_q, rf_dst_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic [31:0]     stall_count_q, stall_count_d;

    logic            alu_gnt, ld_gnt, issue_fire;
    logic [RW-1:0]   gnt_rd;
    logic [XLEN-1:0] gnt_value;

    // Hazard check uses only the registered scoreboard; there is no bypass
    // from the write port, so a reader waits until the register file holds
    // the new value.
    always_comb begin
        issue_stall = issue_valid & (busy_q[issue_rs1] | busy_q[issue_rs2] |
                                     (issue_rd_we & busy_q[issue_rd]));
        issue_fire  = issue_valid & ~issue_stall;
    end

    always_comb begin
        alu_gnt  = 1'b0;
        ld_gnt   = 1'b0;
        rr_ptr_d = rr_ptr_q;
        if (!rst) begin
            if (alu_valid && ld_valid) begin
                ld_gnt   = ~rr_ptr_q;
                alu_gnt  = rr_ptr_q;
                // Pointer moves to the loser only on a contested grant.
                rr_ptr_d = ~rr_ptr_q;
            end else begin
                alu_gnt = alu_valid;
                ld_gnt  = ld_valid;
            end
        end
        gnt_rd    = ld_gnt ? ld_rd    : alu_rd;
        gnt_value = ld_gnt ? ld_value : alu_value;
    end

    always_comb begin
        rf_we_d    = 1'b0;
        rf_dst_d   = rf_dst_q;
        rf_wdata_d = rf_wdata_q;
        if (alu_gnt || ld_gnt) begin
            // A write to x0 is consumed but never reaches the register file.
            rf_we_d    = (gnt_rd != '0);
            rf_dst_d   = gnt_rd;
            rf_wdata_d = gnt_value;
        end
    end

    always_comb begin
        busy_d = busy_q;
        // Clear first so a same-edge set of the same register wins.
        if (rf_we_q) busy_d[rf_dst_q] = 1'b0;
        if (issue_fire && issue_rd_we && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (issue_stall && (stall_count_q != 32'hFFFF_FFFF))
            stall_count_d = stall_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= '0;
            rr_ptr_q      <= 1'b0;
            rf_we_q       <= 1'b0;
            rf_dst_q      <= '0;
            rf_wdata_q    <= '0;
            stall_count_q <= '0;
        end else begin
            busy_q        <= busy_d;
            rr_ptr_q      <= rr_ptr_d;
            rf_we_q       <= rf_we_d;
            rf_dst_q      <= rf_dst_d;
            rf_wdata_q    <= rf_wdata_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign alu_ready   = alu_gnt;
    assign ld_ready    = ld_gnt;
    assign rf_we       = rf_we_q;
    assign rf_dst      = rf_dst_q;
    assign rf_wdata    = rf_wdata_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_rd_we;
    logic        issue_stall;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_value;
    logic        alu_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_value;
    logic        ld_ready;
    logic        rf_we;
    logic [4:0]  rf_dst;
    logic [31:0] rf_wdata;
    logic [31:0] stall_count;

    int total = 0;
    int bad   = 0;

    regfile_wb_scheduler dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .issue_stall(issue_stall),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_value(alu_value), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_value(ld_value), .ld_ready(ld_ready),
        .rf_we(rf_we), .rf_dst(rf_dst), .rf_wdata(rf_wdata), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        issue_valid = 1'b0; issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd0; issue_rd_we = 1'b0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_value = 32'd0;
        ld_valid = 1'b0; ld_rd = 5'd0; ld_value = 32'd0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic we);
        issue_valid = 1'b1; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd; issue_rd_we = we;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd1; ld_valid = 1'b1; ld_rd = 5'd2;
        #1;
        total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL rst_alu_ready got=%b want=0", alu_ready); end
        total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL rst_ld_ready got=%b want=0", ld_ready); end
        nxt();
        rst = 1'b0;
        idle_inputs();
        issue(5'd5, 5'd0, 5'd0, 1'b0);
        #1;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rst_rf_we got=%b want=0", rf_we); end
        total++; if (rf_dst !== 5'd0) begin bad++; $display("FAIL rst_rf_dst got=%0d want=0", rf_dst); end
        total++; if (rf_wdata !== 32'd0) begin bad++; $display("FAIL rst_rf_wdata got=%h want=0", rf_wdata); end
        total++; if (stall_count !== 32'd0) begin bad++; $display("FAIL rst_stall_count got=%0d want=0", stall_count); end
        total++; if (issue_stall !== 1'b0) begin bad++; $display("FAIL rst_issue_stall got=%b want=0", issue_stall); end
        nxt();
        idle_inputs();
    endtask

    task automatic test_raw;
        issue(5'd0, 5'd0, 5'd5, 1'b1);
        #1;
        total++; if (issue_stall !== 1'b0) begin bad++; $display("FAIL raw_first_issue got=%b want=0", issue_stall); end
        nxt();
        issue(5'd5, 5'd0, 5'd6, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (issue_stall !== 1'b1) begin bad++; $display("FAIL raw_stall_%0d got=%b want=1", i, issue_stall); end
            nxt();
        end
        alu_valid = 1'b1; alu_rd = 5'd5; alu_value = 32'hDEAD_BEEF;
        #1;
        total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL raw_alu_ready got=%b want=1", alu_ready); end
        total++; if (issue_stall !== 1'b1) begin bad++; $display("FAIL raw_stall_T got=%b want=1", issue_stall); end
        nxt();
        alu_valid = 1'b0;
        #1;
        total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL raw_rf_we got=%b want=1", rf_we); end
        total++; if (rf_dst !== 5'd5) begin bad++; $display("FAIL raw_rf_dst got=%0d want=5", rf_dst); end
        total++; if (rf_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL raw_rf_wdata got=%h want=deadbeef", rf_wdata); end
        total++; if (issue_stall !== 1'b1) begin bad++; $display("FAIL raw_stall_T1 got=%b want=1", issue_stall); end
        nxt();
        #1;
        total++; if (issue_stall !== 1'b0) begin bad++; $display("FAIL raw_unstall_T2 got=%b want=0", issue_stall); end
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL raw_rf_we_T2 got=%b want=0", rf_we); end
        total++; if (stall_count !== 32'd4) begin bad++; $display("FAIL raw_stall_count got=%0d want=4", stall_count); end
        nxt();
        idle_inputs();
    endtask

    task automatic test_round_robin;
        int ld_n = 0;
        int alu_n = 0;
        logic [4:0]  exp_dst = 5'd0;
        logic [31:0] exp_val = 32'd0;
        logic        exp_ld;
        for (int k = 0; k < 4; k++) begin
            ld_valid = 1'b1;  ld_rd  = 5'd10 + 5'(ld_n);  ld_value  = 32'h1000 + 32'(ld_rd);
            alu_valid = 1'b1; alu_rd = 5'd20 + 5'(alu_n); alu_value = 32'h2000 + 32'(alu_rd);
            #1;
            exp_ld = (k % 2 == 0);
            total++; if (ld_ready !== exp_ld) begin bad++; $display("FAIL rr_ld_ready_%0d got=%b want=%b", k, ld_ready, exp_ld); end
            total++; if (alu_ready !== !exp_ld) begin bad++; $display("FAIL rr_alu_ready_%0d got=%b want=%b", k, alu_ready, !exp_ld); end
            if (k > 0) begin
                total++; if (rf_we !== 1'b1 || rf_dst !== exp_dst || rf_wdata !== exp_val) begin
                    bad++; $display("FAIL rr_wb_%0d got we=%b dst=%0d data=%h want we=1 dst=%0d data=%h",
                                    k, rf_we, rf_dst, rf_wdata, exp_dst, exp_val);
                end
            end
            exp_dst = exp_ld ? ld_rd : alu_rd;
            exp_val = exp_ld ? ld_value : alu_value;
            if (exp_ld) ld_n++; else alu_n++;
            nxt();
        end
        ld_valid = 1'b0; alu_valid = 1'b0;
        #1;
        total++; if (rf_we !== 1'b1 || rf_dst !== 5'd21 || rf_wdata !== 32'h2015) begin
            bad++; $display("FAIL rr_last_wb got we=%b dst=%0d data=%h want we=1 dst=21 data=00002015", rf_we, rf_dst, rf_wdata);
        end
        nxt();
        total++; if (rf_we !== 1'b0 || rf_dst !== 5'd21) begin
            bad++; $display("FAIL rr_hold got we=%b dst=%0d want we=0 dst=21", rf_we, rf_dst);
        end
        idle_inputs();
    endtask

    task automatic test_rd0_and_waw;
        issue(5'd0, 5'd0, 5'd7, 1'b1);
        #1;
        total++; if (issue_stall !== 1'b0) begin bad++; $display("FAIL waw_set7 got=%b want=0", issue_stall); end
        nxt();
        issue_valid = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd0; ld_value = 32'h1234;
        #1;
        total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL rd0_ld_ready got=%b want=1", ld_ready); end
        nxt();
        ld_valid = 1'b0;
        issue(5'd0, 5'd0, 5'd7, 1'b1);
        #1;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rd0_rf_we got=%b want=0", rf_we); end
        total++; if (rf_wdata !== 32'h1234) begin bad++; $display("FAIL rd0_rf_wdata got=%h want=00001234", rf_wdata); end
        total++; if (issue_stall !== 1'b1) begin bad++; $display("FAIL waw_stall got=%b want=1", issue_stall); end
        nxt();
        issue(5'd0, 5'd0, 5'd0, 1'b1);
        #1;
        total++; if (issue_stall !== 1'b0) begin bad++; $display("FAIL x0_no_stall got=%b want=0", issue_stall); end
        nxt();
        issue(5'd7, 5'd0, 5'd0, 1'b0);
        #1;
        total++; if (issue_stall !== 1'b1) begin bad++; $display("FAIL busy7_kept got=%b want=1", issue_stall); end
        nxt();
        idle_inputs();
    endtask

    task automatic test_reset_mid;
        issue(5'd0, 5'd0, 5'd3, 1'b1);
        nxt();
        issue(5'd0, 5'd0, 5'd9, 1'b1);
        ld_valid = 1'b1; ld_rd = 5'd12; ld_value = 32'hAA;
        alu_valid = 1'b1; alu_rd = 5'd13; alu_value = 32'hBB;
        #1;
        total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL mid_pre_ld_ready got=%b want=1", ld_ready); end
        nxt();
        issue_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (alu_ready !== 1'b0 || ld_ready !== 1'b0) begin
            bad++; $display("FAIL mid_rst_ready got alu=%b ld=%b want 0 0", alu_ready, ld_ready);
        end
        nxt();
        rst = 1'b0;
        issue(5'd3, 5'd9, 5'd9, 1'b1);
        #1;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL mid_rf_we got=%b want=0", rf_we); end
        total++; if (stall_count !== 32'd0) begin bad++; $display("FAIL mid_stall_count got=%0d want=0", stall_count); end
        total++; if (issue_stall !== 1'b0) begin bad++; $display("FAIL mid_busy_cleared got=%b want=0", issue_stall); end
        total++; if (ld_ready !== 1'b1 || alu_ready !== 1'b0) begin
            bad++; $display("FAIL mid_rr_load_first got ld=%b alu=%b want 1 0", ld_ready, alu_ready);
        end
        nxt();
        idle_inputs();
    endtask

    task automatic test_saturate;
        issue(5'd0, 5'd0, 5'd4, 1'b1);
        nxt();
        issue(5'd4, 5'd0, 5'd0, 1'b0);
        force dut.stall_count_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_count_q;
        #1;
        total++; if (stall_count !== 32'hFFFF_FFFD || issue_stall !== 1'b1) begin
            bad++; $display("FAIL sat_preload got cnt=%h stall=%b want cnt=fffffffd stall=1", stall_count, issue_stall);
        end
        nxt();
        total++; if (stall_count !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sat_inc got=%h want=fffffffe", stall_count); end
        for (int i = 0; i < 3; i++) begin
            nxt();
            total++; if (stall_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_hold_%0d got=%h want=ffffffff", i, stall_count); end
        end
        idle_inputs();
        nxt();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        nxt();
        test_reset();
        test_raw();
        test_round_robin();
        test_rd0_and_waw();
        test_reset_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Sequences all writes into the 32x32 register file (two read ports, one write port, x0 hardwired zero, write on posedge) and gates instruction issue against it.
- Two writeback sources share the single write port under round-robin arbitration: ALU results and load results.
- A 32-bit busy scoreboard marks destinations with in-flight writes and stalls issue on RAW/WAW hazards until the register file holds the new value.
- Sits between the decode/issue stage, the execute/load units and the register file write port.

Parameters:
- NREG, 32, number of architectural registers; scoreboard width.
- XLEN, 32, data width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  decode presents an instruction.
- issue_rs1  in  5  source register 1.
- issue_rs2  in  5  source register 2.
- issue_rd  in  5  destination register.
- issue_rd_we  in  1  instruction writes issue_rd.
- issue_stall  out  1  hazard; instruction not accepted this cycle.
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  5  ALU destination.
- alu_value  in  XLEN  ALU result.
- alu_ready  out  1  ALU request granted this cycle.
- ld_valid  in  1  load writeback request.
- ld_rd  in  5  load destination.
- ld_value  in  XLEN  load data.
- ld_ready  out  1  load request granted this cycle.
- rf_we  out  1  register file write enable (registered).
- rf_dst  out  5  register file destination (registered).
- rf_wdata  out  XLEN  register file write data (registered).
- stall_count  out  32  saturating count of stalled issue cycles.

Behaviour:
- Reset: busy=0, rr_ptr=0 (load favoured first), rf_we=0, rf_dst=0, rf_wdata=0, stall_count=0. Reset mid-operation discards all pending writes and busy bits. No grant or ready is asserted while rst=1.
- Issue stall (combinational from registered busy only, no bypass): issue_stall = issue_valid & (busy[rs1] | busy[rs2] | (issue_rd_we & busy[rd])). busy[0] is always 0.
- issue_fire = issue_valid & ~issue_stall. On issue_fire with issue_rd_we=1 and rd!=0, busy[rd] is set at the clock edge.
- Arbitration (combinational):
  - Only one valid: that source is granted.
  - Both valid: rr_ptr=0 grants load, rr_ptr=1 grants ALU. After each contested grant, rr_ptr points to the loser.
  - Uncontested grants leave rr_ptr unchanged.
  - alu_ready / ld_ready equal the respective grant. A requester holds valid/rd/value until it sees ready.
- Write latency: a grant in cycle T registers rf_we/rf_dst/rf_wdata at the end of T. They are presented in T+1, and the register file updates at the end of T+1.
  - rf_we=0 if the granted rd=0 (request still consumed).
  - rf_we deasserts in any cycle with no grant; rf_dst/rf_wdata hold their last values.
- Busy clear: busy[rf_dst] clears at the end of the cycle in which rf_we=1, the same edge the register file writes. An issue reading that register is unstalled the cycle after, when read data is valid.
- Simultaneous set and clear of the same register at one edge: set wins. This is reachable only via rd-based WAW when the register is not busy, so it normally cannot occur; the rule is defined for robustness.
- Writes with no matching busy bit (e.g. after reset) are performed; the clear is a no-op.
- stall_count increments on each cycle with issue_stall=1 and saturates at 32'hFFFF_FFFF.

Test Plan:
- Reset then issue rd=5 (issue_rd_we=1) -> busy[5]=1. Issue with rs1=5 -> issue_stall=1 until ALU wb rd=5 value 32'hDEAD_BEEF is granted at T; rf_we=1, rf_dst=5 in T+1; stall drops in T+2; stall_count equals the stalled cycle count.
- alu_valid and ld_valid both high for 4 cycles (distinct rd) -> grants in order load, ALU, load, ALU; rf_dst sequence matches; never both ready in one cycle.
- Writeback to rd=0 with value 32'h1234 -> ld_ready=1, rf_we=0 next cycle, busy unchanged.
- Issue rd=7 while busy[7] (WAW) -> stalled. Issue rs2=0 with rd=0 -> never stalls.
- Assert rst for one cycle with busy[3], busy[9] set and a grant pending -> next cycle busy=0, rf_we=0, stall_count=0, rr_ptr favours load.
- Force 2^32 stalled cycles (or preload the counter in simulation) -> stall_count holds at 32'hFFFF_FFFF.
